// File: rtl/zrb_uart_pkg.sv
// Shared definitions for the zrb UART blocks: receiver state encoding,
// parity mode constants and a parameter range check.
package zrb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic bit rx_params_ok(input int clk_div, input int oversample,
                                        input int data_bits, input int parity,
                                        input int stop_bits);
        return (clk_div >= 1) && (oversample >= 4) && (oversample % 2 == 0) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/zrb_uart_rx_os_if.sv
// Received-word handshake between the UART receiver (master) and its consumer (slave).
interface zrb_uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ack;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out, data_valid, frame_err, parity_err, overrun,
        input  data_ack
    );

    modport slave (
        input  data_out, data_valid, frame_err, parity_err, overrun,
        output data_ack
    );
endinterface

// File: rtl/zrb_uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every CLK_DIV clocks, held at zero by clear.
module zrb_uart_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = !clear && (count == LAST);
endmodule

// File: rtl/zrb_uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling, false-start rejection,
// frame/parity/overrun flags and a valid/ack output handshake.
module zrb_uart_rx_os
    import zrb_uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic busy,
    zrb_uart_rx_os_if.master rx_if
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    if (!rx_params_ok(CLK_DIV, OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_params
        $error("zrb_uart_rx_os: parameter out of range");
    end

    rx_state_t            state;
    logic                 rx_m, rx_s, rx_s_d;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bidx;
    logic                 sidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 frm_bad, par_bad, done;
    logic                 tick;

    // NOTE: registers take <= so every flop samples the pre-edge value; with = the
    // chain would collapse into one stage in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // Divider idles at zero so the first tick lands CLK_DIV clocks after the start edge.
    zrb_uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            scnt    <= '0;
            bidx    <= '0;
            sidx    <= 1'b0;
            shreg   <= '0;
            frm_bad <= 1'b0;
            par_bad <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Edge, not level: a line held in break cannot retrigger.
                    if (rx_s_d && !rx_s) begin
                        state   <= ST_START;
                        scnt    <= '0;
                        frm_bad <= 1'b0;
                        par_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (scnt == S_MID) begin
                            scnt  <= '0;
                            bidx  <= '0;
                            state <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (scnt == S_END) begin
                            scnt  <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bidx == B_LAST) begin
                                bidx  <= '0;
                                state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bidx <= bidx + 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (scnt == S_END) begin
                            scnt    <= '0;
                            par_bad <= (^shreg) ^ rx_s ^ (PARITY == PAR_ODD);
                            state   <= ST_STOP;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (scnt == S_END) begin
                            scnt <= '0;
                            if (!rx_s)
                                frm_bad <= 1'b1;
                            if (sidx == 1'(STOP_BITS - 1)) begin
                                sidx  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                sidx <= 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completing frame is accepted if the holding register is free or freed this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_if.data_out   <= '0;
            rx_if.data_valid <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_if.data_valid || rx_if.data_ack) begin
                rx_if.data_out   <= shreg;
                rx_if.frame_err  <= frm_bad;
                rx_if.parity_err <= par_bad;
                rx_if.data_valid <= 1'b1;
            end else begin
                rx_if.overrun <= 1'b1;
            end
        end else if (rx_if.data_ack && rx_if.data_valid) begin
            rx_if.data_valid <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_zrb_uart_rx_os.sv
// Directed bench for zrb_uart_rx_os: four instances (8N1, 8E1, 8O2, 8N2) share one serial line.
module tb_zrb_uart_rx_os;
    localparam int BIT_CLKS = 64;   // CLK_DIV=4 x OVERSAMPLE=16
    localparam int N1 = 0, E1 = 1, O2 = 2, N2 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic ack = 1'b0;
    logic busy_n1, busy_e1, busy_o2, busy_n2;
    logic [3:0] dv;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    zrb_uart_rx_os_if #(.DATA_BITS(8)) if_n1 ();
    zrb_uart_rx_os_if #(.DATA_BITS(8)) if_e1 ();
    zrb_uart_rx_os_if #(.DATA_BITS(8)) if_o2 ();
    zrb_uart_rx_os_if #(.DATA_BITS(8)) if_n2 ();

    assign if_n1.data_ack = ack;
    assign if_e1.data_ack = ack;
    assign if_o2.data_ack = ack;
    assign if_n2.data_ack = ack;
    assign dv = {if_n2.data_valid, if_o2.data_valid, if_e1.data_valid, if_n1.data_valid};

    zrb_uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_n1 (.clk(clk), .reset(reset), .rx(rx), .busy(busy_n1), .rx_if(if_n1));
    zrb_uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_e1 (.clk(clk), .reset(reset), .rx(rx), .busy(busy_e1), .rx_if(if_e1));
    zrb_uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
        u_o2 (.clk(clk), .reset(reset), .rx(rx), .busy(busy_o2), .rx_if(if_o2));
    zrb_uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        u_n2 (.clk(clk), .reset(reset), .rx(rx), .busy(busy_n2), .rx_if(if_n2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ack   = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Called right after a negedge; leaves the line idle high.
    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                              input int nstop, input logic stop2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(1'b1);
        if (nstop == 2) send_bit(stop2);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int idx, input int budget);
        int n = 0;
        while (!dv[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(dv[idx]), 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state, observed while reset is held
        repeat (3) @(negedge clk);
        check("rst_data",   32'(if_n1.data_out),   32'h0);
        check("rst_valid",  32'(if_n1.data_valid), 32'h0);
        check("rst_ferr",   32'(if_n1.frame_err),  32'h0);
        check("rst_perr",   32'(if_n1.parity_err), 32'h0);
        check("rst_ovr",    32'(if_n1.overrun),    32'h0);
        check("rst_busy",   32'(busy_n1),          32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0xA5: stop mid-sample is 611 clocks after the start edge is driven,
        // data_valid is visible from the negedge after clock 612.
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (611) @(negedge clk);
                check("lat_before", 32'(if_n1.data_valid), 32'd0);
                @(negedge clk);
                check("lat_after",  32'(if_n1.data_valid), 32'd1);
            end
        join
        check("a5_data", 32'(if_n1.data_out),   32'hA5);
        check("a5_ferr", 32'(if_n1.frame_err),  32'h0);
        check("a5_perr", 32'(if_n1.parity_err), 32'h0);
        do_ack();
        check("a5_ack_clears", 32'(if_n1.data_valid), 32'h0);

        // 20-clock low glitch: false start rejected
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy", 32'(busy_n1), 32'd1);
        repeat (100) @(negedge clk);
        check("glitch_idle",  32'(busy_n1),          32'd0);
        check("glitch_valid", 32'(if_n1.data_valid), 32'd0);
        check("glitch_ferr",  32'(if_n1.frame_err),  32'd0);
        check("glitch_ovr",   32'(if_n1.overrun),    32'd0);

        // 8E1 0x3C (four ones) with parity bit 1: wrong
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1);
        wait_valid(E1, 200);
        check("e1_data", 32'(if_e1.data_out),   32'h3C);
        check("e1_perr", 32'(if_e1.parity_err), 32'd1);
        check("e1_ferr", 32'(if_e1.frame_err),  32'd0);

        // 8O2 0x3C with parity bit 1: correct
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b1, 2, 1'b1);
        wait_valid(O2, 200);
        check("o2_data", 32'(if_o2.data_out),   32'h3C);
        check("o2_perr", 32'(if_o2.parity_err), 32'd0);
        check("o2_ferr", 32'(if_o2.frame_err),  32'd0);

        // 8N2 with second stop bit low
        do_reset();
        send_frame(8'h96, 1'b0, 1'b0, 2, 1'b0);
        wait_valid(N2, 200);
        check("n2_data", 32'(if_n2.data_out),   32'h96);
        check("n2_ferr", 32'(if_n2.frame_err),  32'd1);
        check("n2_perr", 32'(if_n2.parity_err), 32'd0);

        // Break: 30 bit times low gives exactly one frame
        do_reset();
        rx = 1'b0;
        repeat (30 * BIT_CLKS) @(negedge clk);
        check("brk_valid", 32'(if_n1.data_valid), 32'd1);
        check("brk_data",  32'(if_n1.data_out),   32'h00);
        check("brk_ferr",  32'(if_n1.frame_err),  32'd1);
        check("brk_ovr",   32'(if_n1.overrun),    32'd0);
        check("brk_busy",  32'(busy_n1),          32'd0);
        do_ack();
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(8'hC3, 1'b0, 1'b0, 1, 1'b1);
        wait_valid(N1, 200);
        check("post_brk_data", 32'(if_n1.data_out),  32'hC3);
        check("post_brk_ferr", 32'(if_n1.frame_err), 32'd0);
        do_ack();

        // Back-to-back frames without ack: second frame overruns
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1);
        check("ovr_valid", 32'(if_n1.data_valid), 32'd1);
        check("ovr_data",  32'(if_n1.data_out),   32'h11);
        check("ovr_flag",  32'(if_n1.overrun),    32'd1);
        do_ack();
        check("ovr_ack_valid", 32'(if_n1.data_valid), 32'd0);
        check("ovr_ack_flag",  32'(if_n1.overrun),    32'd0);
        send_frame(8'h44, 1'b0, 1'b0, 1, 1'b1);
        check("hold_data", 32'(if_n1.data_out), 32'h44);
        // Ack lands in the completion cycle of 0x33 while 0x44 is still held
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (611) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                check("ackcmp_data",  32'(if_n1.data_out),   32'h33);
                check("ackcmp_valid", 32'(if_n1.data_valid), 32'd1);
                check("ackcmp_ovr",   32'(if_n1.overrun),    32'd0);
            end
        join
        check("ackcmp_hold", 32'(if_n1.data_valid), 32'd1);

        // Asynchronous reset in the middle of 0xFF, then a clean frame
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (300) @(negedge clk);
                check("mid_busy", 32'(busy_n1), 32'd1);
                #2 reset = 1'b1;
                #1;
                check("arst_data",  32'(if_n1.data_out),   32'h0);
                check("arst_valid", 32'(if_n1.data_valid), 32'd0);
                check("arst_busy",  32'(busy_n1),          32'd0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
        join
        check("arst_no_frame", 32'(if_n1.data_valid), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1, 1'b1);
        wait_valid(N1, 200);
        check("after_rst_data", 32'(if_n1.data_out),   32'h5A);
        check("after_rst_ferr", 32'(if_n1.frame_err),  32'd0);
        check("after_rst_perr", 32'(if_n1.parity_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
